data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
Parametrised word-organised data memory with a full RV32I load/store unit.
- Executes LB, LH, LW, LBU, LHU, SB, SH and SW, selected by the operation codes in instruction_param.vh.
- Loads return sign- or zero-extended data through the registered register-file write port. Stores perform byte-lane merges.
- Detects misaligned accesses, and optionally out-of-range accesses. Sits in the execute/memory stage, beside the ALU and branch unit.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words; power of two, minimum 4
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned
IDX_W, $clog2(DEPTH_WORDS), local parameter: word index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
jump_branch_enable  in  1  when 1, operation this cycle is squashed
src1_value  in  32  base address operand (rs1)
src2_value  in  32  store data (rs2)
imm  in  32  sign-extended offset
rd  in  5  load destination register
operation_con  in  6  operation code; non-load/store codes are no-ops
write_req  out  1  register-file write strobe
write_addr  out  5  register-file write index
write_data  out  32  register-file write data
misalign_fault  out  1  one-cycle pulse on a misaligned access
access_fault  out  1  one-cycle pulse on an out-of-range access (feature-dependent)
fault_addr  out  32  effective address of the most recent fault

Behaviour:
- Reset and clock: reset_n is asynchronous, active-low; clock is clk.
- Reset values: write_req, write_addr, write_data, misalign_fault, access_fault and fault_addr all reset to 0. Memory contents are not reset.
- Address arithmetic:
  - Effective address ea = src1_value + imm, modulo 2^32.
  - off = ea - BASE_ADDR.
  - idx = off[IDX_W+1:2].
  - lane = ea[1:0].
- Alignment: LH, LHU and SH require lane[0]=0. LW and SW require lane=0. Byte operations are never misaligned.
- Memory access timing:
  - All memory writes and output updates happen on posedge clk.
  - A load's write_req/write_data are valid in the cycle after the operation is presented (latency 1). This is a single-cycle throughput pipeline with no stall.
- Loads:
  - LB/LBU select byte (lane*8+7 : lane*8).
  - LH/LHU select halfword (lane[1]*16+15 : lane[1]*16).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - write_addr <= rd; write_req <= 1, except write_req <= 0 when rd==0.
- Stores:
  - SB writes only the addressed byte lane; SH writes two lanes; SW writes all four.
  - Unwritten lanes are preserved.
  - write_req <= 0.
- Hold behaviour: when write_req <= 0, write_addr and write_data hold their previous values.
- Squash: jump_branch_enable=1 means no memory write and write_req <= 0, with both faults 0.
- Misalignment: no memory write; write_req <= 0; misalign_fault <= 1 for one cycle; fault_addr <= ea.
- Fault pulses: misalign_fault and access_fault are 0 in every cycle not described above.
- Store-then-load: a store followed by a load to the same word on the next cycle returns the merged new data. Only one operation is presented per cycle, so no read/write collision exists.
- Reset mid-operation: an operation presented while reset_n=0 is discarded, and memory is not written. An output pulse present at reset assertion clears immediately.
- Non-memory operation codes: write_req <= 0; no side effects.

Optional Feature:
DMEM_BOUNDS_CHECK_EN.
- Defined:
  - An access with off >= 4*DEPTH_WORDS is out of range. The compare is unsigned, so ea below BASE_ADDR is also out of range.
  - An out-of-range access performs no memory write and sets write_req <= 0.
  - It pulses access_fault for one cycle and sets fault_addr <= ea.
  - Misalignment takes priority when both conditions hold: only misalign_fault pulses.
- Undefined: idx wraps modulo DEPTH_WORDS, and access_fault is tied 0.

Test Plan:
1. Reset, then SW src1=0x10 imm=4 src2=0xDEADBEEF. Next cycle LW rd=5 at the same address. Required response one cycle later: write_req=1, write_addr=5, write_data=0xDEADBEEF.
2. SB of 0x80 at ea=0x15, then LB rd=3 and LBU rd=4 at 0x15, then LW at 0x14. Required responses: 0xFFFFFF80, then 0x00000080, then 0xDEAD80EF.
3. SH 0x1234 at ea=0x16, then LHU at 0x16, then LW at 0x14. Required responses: 0x00001234, then 0x123480EF.
4. LW at ea=0x13, then SH at ea=0x11. Required response for each: misalign_fault pulses for exactly 1 cycle, fault_addr equals 0x13 and then 0x11, write_req=0. A following LW at 0x10 returns the memory unchanged.
5. LW with rd=0, and separately SW with jump_branch_enable=1. Required response: write_req=0 for both, and the squashed store leaves memory unchanged when checked by a later LW.
6. DEPTH_WORDS=128, LW at ea=0x200.
   - With DMEM_BOUNDS_CHECK_EN: access_fault=1, fault_addr=0x200, write_req=0.
   - Without DMEM_BOUNDS_CHECK_EN: returns word 0 contents.
   - Assert reset_n mid-sequence: all outputs become 0 asynchronously.

Source files
------------

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - word-organised data memory with RV32I load/store unit
// Optional out-of-range detection is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jump_branch_enable,
  input  logic [31:0] src1_value,
  input  logic [31:0] src2_value,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [5:0]  operation_con,
  output logic        write_req,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        misalign_fault,
  output logic        access_fault,
  output logic [31:0] fault_addr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam int OFF_W = 32;
`else
  localparam int OFF_W = IDX_W + 2;
`endif

  localparam logic [5:0] OP_LB  = 6'd16;
  localparam logic [5:0] OP_LH  = 6'd17;
  localparam logic [5:0] OP_LW  = 6'd18;
  localparam logic [5:0] OP_LBU = 6'd20;
  localparam logic [5:0] OP_LHU = 6'd21;
  localparam logic [5:0] OP_SB  = 6'd24;
  localparam logic [5:0] OP_SH  = 6'd25;
  localparam logic [5:0] OP_SW  = 6'd26;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      ea;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;

  logic is_load, is_store, size_b, size_h, size_w, ld_unsigned;
  logic misal, oor, valid, misal_hit, oor_hit, go;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;

  logic        write_req_q, write_req_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  // BASE_ADDR is word aligned, so the low two offset bits equal ea[1:0].
  assign ea   = src1_value + imm;
  assign off  = ea[OFF_W-1:0] - BASE_ADDR[OFF_W-1:0];
  assign idx  = off[IDX_W+1:2];
  assign lane = off[1:0];

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    size_b      = 1'b0;
    size_h      = 1'b0;
    size_w      = 1'b0;
    ld_unsigned = 1'b0;
    case (operation_con)
      OP_LB:  begin is_load = 1'b1; size_b = 1'b1; end
      OP_LH:  begin is_load = 1'b1; size_h = 1'b1; end
      OP_LW:  begin is_load = 1'b1; size_w = 1'b1; end
      OP_LBU: begin is_load = 1'b1; size_b = 1'b1; ld_unsigned = 1'b1; end
      OP_LHU: begin is_load = 1'b1; size_h = 1'b1; ld_unsigned = 1'b1; end
      OP_SB:  begin is_store = 1'b1; size_b = 1'b1; end
      OP_SH:  begin is_store = 1'b1; size_h = 1'b1; end
      OP_SW:  begin is_store = 1'b1; size_w = 1'b1; end
      default: ;
    endcase
  end

  assign misal = (size_h & lane[0]) | (size_w & (|lane));
`ifdef DMEM_BOUNDS_CHECK_EN
  // Unsigned compare: addresses below BASE_ADDR wrap to large offsets.
  assign oor = |off[OFF_W-1:IDX_W+2];
`else
  assign oor = 1'b0;
`endif

  assign valid     = (is_load | is_store) & ~jump_branch_enable;
  assign misal_hit = valid & misal;
  assign oor_hit   = valid & ~misal & oor;
  assign go        = valid & ~misal & ~oor;

  always_comb begin
    be    = 4'b0000;
    wdata = src2_value;
    if (size_b) begin
      be    = 4'b0001 << lane;
      wdata = {4{src2_value[7:0]}};
    end else if (size_h) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{src2_value[15:0]}};
    end else if (size_w) begin
      be    = 4'b1111;
    end
  end

  // Memory is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && go && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  always_comb begin
    load_val = rword;
    if (size_b)      load_val = {{24{~ld_unsigned & rbyte[7]}}, rbyte};
    else if (size_h) load_val = {{16{~ld_unsigned & rhalf[15]}}, rhalf};
  end

  assign write_req_d  = go & is_load & (rd != 5'd0);
  assign write_addr_d = write_req_d ? rd : write_addr_q;
  assign write_data_d = write_req_d ? load_val : write_data_q;
  assign misalign_d   = misal_hit;
  assign fault_addr_d = (misal_hit | oor_hit) ? ea : fault_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_req_q  <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= 32'd0;
      misalign_q   <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      write_req_q  <= write_req_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  logic access_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) access_q <= 1'b0;
    else          access_q <= oor_hit;
  end

  assign access_fault = access_q;
`else
  assign access_fault = 1'b0;
`endif

  assign write_req      = write_req_q;
  assign write_addr     = write_addr_q;
  assign write_data     = write_data_q;
  assign misalign_fault = misalign_q;
  assign fault_addr     = fault_addr_q;

endmodule
